// File: rtl/menu_selector.sv
// Menu selection controller: debounces up/down/confirm buttons, tracks the highlighted
// entry, refreshes the one-hot sprite highlight only at frame start, and locks after a confirm.
module menu_selector #(
    parameter int NUM_BUTTONS     = 3,
    parameter int DEBOUNCE_CYCLES = 742500,
    parameter int DEFAULT_INDEX   = 0,
    parameter int WRAP            = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           btn_up_in,
    input  logic                           btn_down_in,
    input  logic                           btn_confirm_in,
    input  logic                           new_frame_in,
    input  logic                           unlock_in,
    output logic [NUM_BUTTONS-1:0]         selected_out,
    output logic [$clog2(NUM_BUTTONS)-1:0] index_out,
    output logic                           confirm_valid_out,
    output logic [$clog2(NUM_BUTTONS)-1:0] confirm_index_out,
    output logic                           locked_out
);

    localparam int IDX_W = $clog2(NUM_BUTTONS);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [IDX_W-1:0]       LAST_IDX       = IDX_W'(NUM_BUTTONS - 1);
    localparam logic [IDX_W-1:0]       DEFAULT_IDX    = IDX_W'(DEFAULT_INDEX);
    localparam logic [NUM_BUTTONS-1:0] DEFAULT_ONEHOT = NUM_BUTTONS'(1) << DEFAULT_INDEX;
    localparam logic [CNT_W-1:0]       CNT_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {ACTIVE, LOCKED} state_t;

    // Button order: 0 = up, 1 = down, 2 = confirm
    logic [2:0] raw;
    logic [2:0] press;

    assign raw = {btn_confirm_in, btn_down_in, btn_up_in};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_d_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= raw[gi];
                    sync2_reg    <= sync1_reg;
                    stable_d_reg <= stable_reg;
                    // Any sample agreeing with the stable level restarts the count
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        stable_reg <= ~stable_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign press[gi] = stable_reg & ~stable_d_reg;
        end
    endgenerate

    logic                   up_press;
    logic                   down_press;
    logic                   confirm_press;

    assign up_press      = press[0];
    assign down_press    = press[1];
    assign confirm_press = press[2];

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       index_reg, index_next;
    logic                   conf_valid_reg, conf_valid_next;
    logic [IDX_W-1:0]       conf_index_reg, conf_index_next;
    logic [NUM_BUTTONS-1:0] selected_reg, selected_next;
    logic [IDX_W-1:0]       idx_dec;
    logic [IDX_W-1:0]       idx_inc;
    logic [NUM_BUTTONS-1:0] index_onehot;

    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_onehot
            assign index_onehot[gi] = (index_reg == IDX_W'(gi));
        end
    endgenerate

    // End handling by explicit compare so non-power-of-two counts stay in range
    always_comb begin
        idx_dec = index_reg - IDX_W'(1);
        idx_inc = index_reg + IDX_W'(1);
        if (index_reg == '0) begin
            idx_dec = (WRAP != 0) ? LAST_IDX : '0;
        end
        if (index_reg == LAST_IDX) begin
            idx_inc = (WRAP != 0) ? '0 : LAST_IDX;
        end
    end

    always_comb begin
        state_next      = state_reg;
        index_next      = index_reg;
        conf_valid_next = 1'b0;
        conf_index_next = conf_index_reg;
        selected_next   = new_frame_in ? index_onehot : selected_reg;
        case (state_reg)
            ACTIVE: begin
                if (confirm_press) begin
                    conf_valid_next = 1'b1;
                    conf_index_next = index_reg;
                    state_next      = LOCKED;
                end else if (up_press && !down_press) begin
                    index_next = idx_dec;
                end else if (down_press && !up_press) begin
                    index_next = idx_inc;
                end
            end
            LOCKED: begin
                if (unlock_in) begin
                    state_next = ACTIVE;
                end
            end
            default: state_next = ACTIVE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg      <= ACTIVE;
            index_reg      <= DEFAULT_IDX;
            conf_valid_reg <= 1'b0;
            conf_index_reg <= '0;
            selected_reg   <= DEFAULT_ONEHOT;
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            conf_valid_reg <= conf_valid_next;
            conf_index_reg <= conf_index_next;
            selected_reg   <= selected_next;
        end
    end

    assign selected_out      = selected_reg;
    assign index_out         = index_reg;
    assign confirm_valid_out = conf_valid_reg;
    assign confirm_index_out = conf_index_reg;
    assign locked_out        = (state_reg == LOCKED);

endmodule

// File: tb/tb_menu_selector.sv
// Directed bench for menu_selector: a wrapping instance and a saturating instance
// share stimulus; expected values are hand-derived for DEBOUNCE_CYCLES = 4.
module tb_menu_selector;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       btn_up_in = 1'b0;
    logic       btn_down_in = 1'b0;
    logic       btn_confirm_in = 1'b0;
    logic       new_frame_in = 1'b0;
    logic       unlock_in = 1'b0;

    logic [2:0] selected_out;
    logic [1:0] index_out;
    logic       confirm_valid_out;
    logic [1:0] confirm_index_out;
    logic       locked_out;

    logic [2:0] sat_selected;
    logic [1:0] sat_index;
    logic       sat_confirm_valid;
    logic [1:0] sat_confirm_index;
    logic       sat_locked;

    int n_checks = 0;
    int n_fail   = 0;
    int cv_count = 0;
    int idx_changes = 0;
    int snap;
    logic [1:0] prev_idx = 2'd0;

    always #5 clk_in = ~clk_in;

    menu_selector #(
        .NUM_BUTTONS(3), .DEBOUNCE_CYCLES(4), .DEFAULT_INDEX(0), .WRAP(1)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .btn_up_in(btn_up_in), .btn_down_in(btn_down_in), .btn_confirm_in(btn_confirm_in),
        .new_frame_in(new_frame_in), .unlock_in(unlock_in),
        .selected_out(selected_out), .index_out(index_out),
        .confirm_valid_out(confirm_valid_out), .confirm_index_out(confirm_index_out),
        .locked_out(locked_out)
    );

    menu_selector #(
        .NUM_BUTTONS(3), .DEBOUNCE_CYCLES(4), .DEFAULT_INDEX(0), .WRAP(0)
    ) dut_sat (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .btn_up_in(btn_up_in), .btn_down_in(btn_down_in), .btn_confirm_in(btn_confirm_in),
        .new_frame_in(new_frame_in), .unlock_in(unlock_in),
        .selected_out(sat_selected), .index_out(sat_index),
        .confirm_valid_out(sat_confirm_valid), .confirm_index_out(sat_confirm_index),
        .locked_out(sat_locked)
    );

    always @(negedge clk_in) begin
        if (confirm_valid_out === 1'b1) cv_count++;
        if (index_out !== prev_idx) idx_changes++;
        prev_idx = index_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic press(input logic u, input logic d, input logic c);
        btn_up_in = u;
        btn_down_in = d;
        btn_confirm_in = c;
        cyc(10);
        btn_up_in = 1'b0;
        btn_down_in = 1'b0;
        btn_confirm_in = 1'b0;
        cyc(10);
    endtask

    task automatic frame();
        new_frame_in = 1'b1;
        cyc(1);
        new_frame_in = 1'b0;
    endtask

    initial begin
        // 1: reset values, then a frame pulse
        cyc(3);
        chk("rst_selected", selected_out, 3'b001);
        chk("rst_index", index_out, 0);
        chk("rst_cvalid", confirm_valid_out, 0);
        chk("rst_cindex", confirm_index_out, 0);
        chk("rst_locked", locked_out, 0);
        rst_n_in = 1'b1;
        cyc(2);
        frame();
        chk("t1_selected", selected_out, 3'b001);
        chk("t1_index", index_out, 0);
        chk("t1_locked", locked_out, 0);
        chk("t1_cvalid", confirm_valid_out, 0);

        // 2: glitch rejected, held press moves once, display waits for frame
        btn_down_in = 1'b1;
        cyc(3);
        btn_down_in = 1'b0;
        cyc(15);
        chk("t2_glitch_index", index_out, 0);
        snap = idx_changes;
        btn_down_in = 1'b1;
        cyc(20);
        btn_down_in = 1'b0;
        cyc(10);
        chk("t2_held_index", index_out, 1);
        chk("t2_held_moves", idx_changes - snap, 1);
        chk("t2_sel_before_frame", selected_out, 3'b001);
        frame();
        chk("t2_sel_after_frame", selected_out, 3'b010);

        // Reset asserted mid debounce count
        btn_down_in = 1'b1;
        cyc(4);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_index", index_out, 0);
        chk("midrst_selected", selected_out, 3'b001);
        chk("midrst_locked", locked_out, 0);
        chk("midrst_cvalid", confirm_valid_out, 0);
        btn_down_in = 1'b0;
        cyc(2);
        rst_n_in = 1'b1;
        cyc(20);
        chk("midrst_after_index", index_out, 0);

        // 3: wrap on the main instance, saturate on the second
        press(1'b1, 1'b0, 1'b0);
        chk("t3_up1_wrap", index_out, 2);
        chk("t3_up1_sat", sat_index, 0);
        press(1'b1, 1'b0, 1'b0);
        chk("t3_up2_wrap", index_out, 1);
        chk("t3_up2_sat", sat_index, 0);
        press(1'b0, 1'b1, 1'b0);
        chk("t3_dn1_wrap", index_out, 2);
        chk("t3_dn1_sat", sat_index, 1);
        press(1'b0, 1'b1, 1'b0);
        chk("t3_dn2_wrap", index_out, 0);
        chk("t3_dn2_sat", sat_index, 2);
        press(1'b0, 1'b1, 1'b0);
        chk("t3_dn3_wrap", index_out, 1);
        chk("t3_dn3_sat", sat_index, 2);
        press(1'b0, 1'b1, 1'b0);
        chk("t3_dn4_wrap", index_out, 2);

        // 4: simultaneous up and down
        press(1'b1, 1'b1, 1'b0);
        chk("t4_index", index_out, 2);
        chk("t4_no_confirm", cv_count, 0);
        chk("t4_locked", locked_out, 0);

        // 5: confirm at index 2 with exact event timing
        btn_confirm_in = 1'b1;
        cyc(6);
        chk("t5_cvalid_early", confirm_valid_out, 0);
        cyc(1);
        chk("t5_cvalid", confirm_valid_out, 1);
        chk("t5_cindex", confirm_index_out, 2);
        chk("t5_locked", locked_out, 1);
        cyc(1);
        chk("t5_cvalid_drop", confirm_valid_out, 0);
        chk("t5_locked_hold", locked_out, 1);
        btn_confirm_in = 1'b0;
        cyc(10);
        chk("t5_events", cv_count, 1);
        press(1'b0, 1'b1, 1'b0);
        chk("t5_locked_down", index_out, 2);
        press(1'b0, 1'b0, 1'b1);
        chk("t5_locked_confirm", cv_count, 1);
        chk("t5_cindex_hold", confirm_index_out, 2);
        unlock_in = 1'b1;
        cyc(1);
        unlock_in = 1'b0;
        chk("t5_unlocked", locked_out, 0);
        press(1'b0, 1'b1, 1'b0);
        chk("t5_down_after_unlock", index_out, 0);

        // 6: confirm press in the same cycle as unlock
        press(1'b0, 1'b0, 1'b1);
        chk("t6_locked", locked_out, 1);
        chk("t6_cindex", confirm_index_out, 0);
        chk("t6_events", cv_count, 2);
        btn_confirm_in = 1'b1;
        cyc(6);
        unlock_in = 1'b1;
        cyc(1);
        unlock_in = 1'b0;
        chk("t6_unlock_wins", locked_out, 0);
        chk("t6_no_cvalid", confirm_valid_out, 0);
        cyc(3);
        chk("t6_events_after", cv_count, 2);
        chk("t6_still_active", locked_out, 0);
        btn_confirm_in = 1'b0;
        cyc(10);

        // Button held through reset release
        rst_n_in = 1'b0;
        btn_up_in = 1'b1;
        cyc(2);
        rst_n_in = 1'b1;
        cyc(6);
        chk("hold_rst_edge6", index_out, 0);
        cyc(1);
        chk("hold_rst_edge7", index_out, 2);
        cyc(15);
        chk("hold_rst_once", index_out, 2);
        chk("hold_rst_locked", locked_out, 0);
        btn_up_in = 1'b0;
        cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/menu_selector.md
Name: menu_selector

Overview:
- Menu selection controller that drives the `selected_in` inputs of the on-screen button sprites.
- Synchronises and debounces three raw push-buttons (up, down, confirm) and tracks the highlighted menu index.
- Publishes a one-hot highlight vector that changes only at frame boundaries, so no sprite changes colour mid-frame.
- On confirm, emits a one-cycle selection event and locks until the game FSM releases it.

Parameters:
- NUM_BUTTONS, 3, number of menu entries (2..8).
- DEBOUNCE_CYCLES, 742500, consecutive stable cycles required to accept a level change (~10 ms at 74.25 MHz).
- DEFAULT_INDEX, 0, index highlighted after reset (< NUM_BUTTONS).
- WRAP, 1, 1 = index wraps at ends; 0 = index saturates at ends.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- btn_up_in  input  1  raw up button, asynchronous, active-high
- btn_down_in  input  1  raw down button, asynchronous, active-high
- btn_confirm_in  input  1  raw confirm button, asynchronous, active-high
- new_frame_in  input  1  one-cycle pulse at start of vertical blank
- unlock_in  input  1  one-cycle pulse from game FSM re-enabling the menu
- selected_out  output  NUM_BUTTONS  one-hot highlight; bit i drives sprite i `selected_in`
- index_out  output  $clog2(NUM_BUTTONS)  current (pending) index, binary
- confirm_valid_out  output  1  one-cycle confirm event
- confirm_index_out  output  $clog2(NUM_BUTTONS)  index captured at confirm; held until next confirm
- locked_out  output  1  high while in LOCKED

Behaviour:
Reset (async assert, sync-free deassert use):
- selected_out = onehot(DEFAULT_INDEX); index_out = DEFAULT_INDEX.
- confirm_valid_out = 0; confirm_index_out = 0; locked_out = 0; state = ACTIVE.
- Sync flops, debounce counters and stable levels = 0.
- Reset mid-operation aborts everything, including any partial debounce count.

Input conditioning (per button):
- 2-flop synchroniser.
- Counter clears whenever the synced level equals the stable level; otherwise it increments.
- When the count reaches DEBOUNCE_CYCLES - 1, the stable level toggles and the counter clears.
- Result: stable goes high on the (DEBOUNCE_CYCLES + 2)th consecutive rising edge sampling raw high.
- Press pulse = stable rising edge; one cycle, combinational from the stable register and its delayed copy.
- Glitches shorter than DEBOUNCE_CYCLES never produce a pulse.
- Holding a button yields exactly one press; there is no auto-repeat.
- A button held through reset release produces one press after debounce.

State machine: ACTIVE, LOCKED.

ACTIVE:
- up press: index <= index - 1. down press: index <= index + 1. index_out updates the next cycle.
- At the ends, WRAP=1 gives 0 -> NUM_BUTTONS-1 and NUM_BUTTONS-1 -> 0; WRAP=0 holds the index.
- up and down pressed in the same cycle: no move.
- confirm press: next cycle confirm_valid_out=1 and confirm_index_out = index before any same-cycle move. Same-cycle up/down moves are discarded. state <= LOCKED.

LOCKED:
- locked_out = 1; all presses are ignored and discarded, with no queuing.
- unlock_in -> ACTIVE on the next edge.
- unlock_in in the same cycle as a confirm press: unlock wins and the confirm is dropped.
- unlock_in while ACTIVE: ignored.

Display update:
- On an edge where new_frame_in = 1, selected_out <= onehot(index_out as of that cycle); otherwise selected_out holds.
- A move coinciding with new_frame_in appears at the following frame.
- selected_out keeps updating while LOCKED, so the confirmed entry stays highlighted.

Arithmetic: index is $clog2(NUM_BUTTONS) bits wide; wrap and saturate are done by explicit compare, never by modulo on non-power-of-two counts.

Test Plan (DEBOUNCE_CYCLES=4, NUM_BUTTONS=3, DEFAULT_INDEX=0, WRAP=1):
1. Reset, then pulse new_frame_in -> selected_out=3'b001, index_out=0, locked_out=0, confirm_valid_out=0; assert rst_n_in mid-count -> all outputs back to reset values immediately.
2. btn_down high 3 cycles then low (glitch) -> index_out stays 0. btn_down held 20 cycles -> index_out=1 exactly once. new_frame_in pulse -> selected_out=3'b010, and not before the pulse.
3. Two up presses from index 0 -> index_out=2 then 1 (wrap). Rerun with WRAP=0: up from 0 stays 0, down from 2 stays 2.
4. up and down debounced simultaneously -> index unchanged; no spurious confirm.
5. At index 2, press confirm -> one-cycle confirm_valid_out with confirm_index_out=2, locked_out=1. Then down and confirm presses -> no change, no second event. unlock_in -> locked_out=0 next cycle; down press -> index_out=0.
6. In LOCKED, confirm press coinciding with unlock_in -> ACTIVE, no confirm_valid_out. Button held high across reset release -> exactly one press after 6 edges.
